// File: rtl/hazard_pkg.sv
// Shared defaults and encodings for the D-stage hazard controller.
package hazard_pkg;

   localparam int HZ_TW       = 3;
   localparam int HZ_NPROD    = 2;
   localparam int HZ_MULT_CYC = 5;
   localparam int HZ_DIV_CYC  = 10;
   localparam int HZ_CNT_W    = 16;

   localparam int FWD_RF        = 0;
   localparam int FWD_PROD_BASE = 1;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2
   } md_kind_e;

   // Counter width able to hold the longer of the two unit latencies.
   function automatic int md_cnt_width(input int mult_cyc, input int div_cyc);
      int m;
      m = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_chk.sv
// Protocol checker: the E stage must not issue mult/div while the unit is busy.
module hazard_stall_ctrl_chk (
   input logic clk,
   input logic reset,
   input logic e_md_start,
   input logic md_busy
);

   a_no_start_while_busy: assert property (
      @(posedge clk) disable iff (reset) !(e_md_start && md_busy)
   );

endmodule

// File: rtl/md_busy_counter.sv
// HI/LO unit occupancy tracker: busy for exactly N cycles after an accepted start.
module md_busy_counter
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = HZ_MULT_CYC,
   parameter int DIV_CYC  = HZ_DIV_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   localparam int CW = md_cnt_width(MULT_CYC, DIV_CYC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q;
   md_kind_e      kind_q, kind_d;

   // Next count: a start is only accepted while idle; starts during busy are dropped.
   always_comb begin
      cnt_d  = cnt_q;
      kind_d = kind_q;
      if (start && !busy_q) begin
         cnt_d  = is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
         kind_d = is_div ? MD_DIV : MD_MULT;
      end else if (cnt_q != '0) begin
         cnt_d  = cnt_q - CW'(1);
         kind_d = (cnt_q == CW'(1)) ? MD_IDLE : kind_q;
      end else begin
         cnt_d  = cnt_q;
         kind_d = MD_IDLE;
      end
   end

   // Counter and registered busy flag; reset aborts any running operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         kind_q <= MD_IDLE;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != '0);
         kind_q <= kind_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard controller: Tuse/Tnew stall, nearest-producer forwarding,
// HI/LO busy tracking and a saturating stalled-cycle counter.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter  int TW       = HZ_TW,
   parameter  int NPROD    = HZ_NPROD,
   parameter  int MULT_CYC = HZ_MULT_CYC,
   parameter  int DIV_CYC  = HZ_DIV_CYC,
   parameter  int CNT_W    = HZ_CNT_W,
   localparam int SELW     = (NPROD < 1) ? 1 : $clog2(NPROD + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4:0]          d_rs_addr,
   input  logic [4:0]          d_rt_addr,
   input  logic [TW-1:0]       d_rs_tuse,
   input  logic [TW-1:0]       d_rt_tuse,
   input  logic                d_is_md,
   input  logic [NPROD*5-1:0]  prod_a3,
   input  logic [NPROD-1:0]    prod_we,
   input  logic [NPROD*TW-1:0] prod_tnew,
   input  logic                e_md_start,
   input  logic                e_md_is_div,
   input  logic                cnt_clr,
   output logic                stall,
   output logic                pc_en,
   output logic                fd_en,
   output logic                de_clr,
   output logic [SELW-1:0]     fwd_rs_sel,
   output logic [SELW-1:0]     fwd_rt_sel,
   output logic                md_busy,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic [NPROD-1:0] rs_match_s, rt_match_s;
   logic [NPROD-1:0] rs_haz_s, rt_haz_s;
   logic             md_haz_s, stall_s;
   logic [SELW-1:0]  rs_sel_s, rt_sel_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_busy_s;

   for (genvar k = 0; k < NPROD; k++) begin : g_prod
      logic [4:0]    a3_s;
      logic [TW-1:0] tnew_s;
      assign a3_s   = prod_a3[k*5 +: 5];
      assign tnew_s = prod_tnew[k*TW +: TW];
      assign rs_match_s[k] = (d_rs_addr != 5'd0) && prod_we[k] && (a3_s == d_rs_addr);
      assign rt_match_s[k] = (d_rt_addr != 5'd0) && prod_we[k] && (a3_s == d_rt_addr);
      assign rs_haz_s[k]   = rs_match_s[k] && (d_rs_tuse < tnew_s);
      assign rt_haz_s[k]   = rt_match_s[k] && (d_rt_tuse < tnew_s);
   end

   // Priority encode: scanning from the far end lets the nearest producer overwrite.
   always_comb begin
      rs_sel_s = SELW'(FWD_RF);
      rt_sel_s = SELW'(FWD_RF);
      for (int k = NPROD - 1; k >= 0; k--) begin
         rs_sel_s = rs_match_s[k] ? SELW'(FWD_PROD_BASE + k) : rs_sel_s;
         rt_sel_s = rt_match_s[k] ? SELW'(FWD_PROD_BASE + k) : rt_sel_s;
      end
   end

   md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md (
      .clk    (clk),
      .reset  (reset),
      .start  (e_md_start),
      .is_div (e_md_is_div),
      .busy   (md_busy_s)
   );

   hazard_stall_ctrl_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .e_md_start (e_md_start),
      .md_busy    (md_busy_s)
   );

   assign md_haz_s = d_is_md && (md_busy_s || e_md_start);
   assign stall_s  = (|rs_haz_s) || (|rt_haz_s) || md_haz_s;

   // Stall counter next state: clear dominates, increment saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall      = stall_s;
   assign pc_en      = ~stall_s;
   assign fd_en      = ~stall_s;
   assign de_clr     = stall_s;
   assign fwd_rs_sel = rs_sel_s;
   assign fwd_rt_sel = rt_sel_s;
   assign md_busy    = md_busy_s;
   assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then random traffic
// against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;

   localparam int TW = 3;
   localparam int NP = 2;
   localparam int MULT_N = 5;
   localparam int DIV_N = 10;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] rs_addr, rt_addr;
   logic [TW-1:0] rs_tuse, rt_tuse;
   logic is_md, md_start, md_is_div, clr;
   logic [4:0] a3 [NP];
   logic we [NP];
   logic [TW-1:0] tnew [NP];
   logic [NP*5-1:0] prod_a3;
   logic [NP-1:0] prod_we;
   logic [NP*TW-1:0] prod_tnew;

   logic stall, pc_en, fd_en, de_clr, md_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic [15:0] stall_cnt;
   logic s_stall, s_pc_en, s_fd_en, s_de_clr, s_md_busy;
   logic [1:0] s_rs_sel, s_rt_sel;
   logic [3:0] s_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int md_end = -1;
   int acc = 0;
   logic exp_stall;

   always #5 clk = ~clk;

   assign prod_a3   = {a3[1], a3[0]};
   assign prod_we   = {we[1], we[0]};
   assign prod_tnew = {tnew[1], tnew[0]};

   hazard_stall_ctrl dut (
      .clk(clk), .reset(reset), .d_rs_addr(rs_addr), .d_rt_addr(rt_addr),
      .d_rs_tuse(rs_tuse), .d_rt_tuse(rt_tuse), .d_is_md(is_md),
      .prod_a3(prod_a3), .prod_we(prod_we), .prod_tnew(prod_tnew),
      .e_md_start(md_start), .e_md_is_div(md_is_div), .cnt_clr(clr),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   hazard_stall_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .d_rs_addr(rs_addr), .d_rt_addr(rt_addr),
      .d_rs_tuse(rs_tuse), .d_rt_tuse(rt_tuse), .d_is_md(is_md),
      .prod_a3(prod_a3), .prod_we(prod_we), .prod_tnew(prod_tnew),
      .e_md_start(md_start), .e_md_is_div(md_is_div), .cnt_clr(clr),
      .stall(s_stall), .pc_en(s_pc_en), .fd_en(s_fd_en), .de_clr(s_de_clr),
      .fwd_rs_sel(s_rs_sel), .fwd_rt_sel(s_rt_sel),
      .md_busy(s_md_busy), .stall_cnt(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_busy();
      return cyc <= md_end;
   endfunction

   // Source hazard against any producer, from the Tuse/Tnew rule.
   function automatic logic src_hazard(input logic [4:0] addr, input logic [TW-1:0] tuse);
      logic h = 1'b0;
      for (int k = 0; k < NP; k++)
         if (addr != 0 && we[k] && a3[k] == addr && tuse < tnew[k]) h = 1'b1;
      return h;
   endfunction

   function automatic logic [1:0] src_fwd(input logic [4:0] addr);
      for (int k = 0; k < NP; k++)
         if (addr != 0 && we[k] && a3[k] == addr) return 2'(k + 1);
      return 2'd0;
   endfunction

   task automatic check_all(input string tag);
      int sat16, sat4;
      #1;
      exp_stall = src_hazard(rs_addr, rs_tuse) | src_hazard(rt_addr, rt_tuse) |
                  (is_md & (model_busy() | md_start));
      sat16 = (acc > 65535) ? 65535 : acc;
      sat4  = (acc > 15) ? 15 : acc;
      chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
      chk({tag, ".pc_en"}, 32'(pc_en), 32'(!exp_stall));
      chk({tag, ".fd_en"}, 32'(fd_en), 32'(!exp_stall));
      chk({tag, ".de_clr"}, 32'(de_clr), 32'(exp_stall));
      chk({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(src_fwd(rs_addr)));
      chk({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(src_fwd(rt_addr)));
      chk({tag, ".md_busy"}, 32'(md_busy), 32'(model_busy()));
      chk({tag, ".cnt"}, 32'(stall_cnt), 32'(sat16));
      chk({tag, ".cnt4"}, 32'(s_cnt), 32'(sat4));
   endtask

   // One clock edge: advance the reference model with the inputs present at the edge.
   task automatic tick();
      @(posedge clk);
      if (clr) acc = 0;
      else if (exp_stall) acc++;
      if (md_start && !model_busy()) md_end = cyc + (md_is_div ? DIV_N : MULT_N);
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      rs_addr = 0; rt_addr = 0; rs_tuse = 0; rt_tuse = 0;
      is_md = 0; md_start = 0; md_is_div = 0; clr = 0;
      for (int k = 0; k < NP; k++) begin
         a3[k] = 0; we[k] = 0; tnew[k] = 0;
      end
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(3, 0))
         0: return 5'd0;
         1: return 5'd8;
         2: return 5'd9;
         default: return 5'd10;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      idle_inputs();
      #3;
      chk("rst.md_busy", 32'(md_busy), 32'd0);
      chk("rst.cnt", 32'(stall_cnt), 32'd0);
      check_all("rst");
      @(posedge clk);
      #1 reset = 1'b0;

      // 1: E producer not ready for rs
      rs_addr = 8; a3[0] = 8; we[0] = 1; tnew[0] = 2; rs_tuse = 0;
      check_all("t1");
      chk("t1.stall_k", 32'(stall), 32'd1);
      chk("t1.fwd_k", 32'(fwd_rs_sel), 32'd1);
      tick();

      // 2: M producer ready for rt, then rt=0
      idle_inputs();
      rt_addr = 9; a3[1] = 9; we[1] = 1; tnew[1] = 0;
      check_all("t2a");
      chk("t2a.fwd_k", 32'(fwd_rt_sel), 32'd2);
      tick();
      rt_addr = 0; a3[1] = 0;
      check_all("t2b");
      chk("t2b.fwd_k", 32'(fwd_rt_sel), 32'd0);
      tick();

      // 3: mult busy window with a waiting HI/LO consumer
      idle_inputs();
      is_md = 1; md_start = 1;
      check_all("t3.c0");
      tick();
      md_start = 0;
      for (int i = 1; i <= 6; i++) begin
         check_all($sformatf("t3.c%0d", i));
         chk($sformatf("t3.busy%0d", i), 32'(md_busy), 32'(i <= 5));
         tick();
      end

      // 4: div aborted by reset in busy cycle 4
      idle_inputs();
      md_start = 1; md_is_div = 1;
      check_all("t4.s");
      tick();
      md_start = 0;
      for (int i = 1; i < 4; i++) begin
         check_all("t4.b");
         tick();
      end
      #2 reset = 1'b1;
      md_end = -1; acc = 0;
      #1;
      chk("t4.rst_busy", 32'(md_busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      is_md = 1;
      check_all("t4.rel");
      chk("t4.rel_stall", 32'(stall), 32'd0);
      tick();

      // 5: stall counting, clear priority, 4-bit saturation
      idle_inputs();
      clr = 1; check_all("t5.clr0"); tick(); clr = 0;
      rs_addr = 8; a3[0] = 8; we[0] = 1; tnew[0] = 3;
      for (int i = 0; i < 3; i++) begin check_all("t5.h"); tick(); end
      chk("t5.three", 32'(stall_cnt), 32'd3);
      clr = 1; check_all("t5.clr"); tick(); clr = 0;
      chk("t5.cleared", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 20; i++) begin check_all("t5.s"); tick(); end
      chk("t5.sat4", 32'(s_cnt), 32'd15);

      // 6: E and M both write rs; stall from whichever violates Tuse
      idle_inputs();
      rs_addr = 8; a3[0] = 8; a3[1] = 8; we[0] = 1; we[1] = 1;
      check_all("t6a");
      chk("t6a.fwd_k", 32'(fwd_rs_sel), 32'd1);
      tick();
      rs_tuse = 1; tnew[1] = 3;
      check_all("t6b");
      chk("t6b.stall_k", 32'(stall), 32'd1);
      tick();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rs_addr = pick_reg(); rt_addr = pick_reg();
         rs_tuse = TW'($urandom_range(7, 0)); rt_tuse = TW'($urandom_range(7, 0));
         for (int k = 0; k < NP; k++) begin
            a3[k] = pick_reg(); we[k] = 1'($urandom_range(1, 0));
            tnew[k] = TW'($urandom_range(7, 0));
         end
         is_md = ($urandom_range(3, 0) == 0);
         md_start = !model_busy() && ($urandom_range(3, 0) == 0);
         md_is_div = 1'($urandom_range(1, 0));
         clr = ($urandom_range(31, 0) == 0);
         check_all("rnd");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
